// File: rtl/scs8hd_evt_pkg.sv
// Shared definitions for the scs8hd_evt event synchroniser slice:
// FSM state encoding, default parameter values and a configuration check.
package scs8hd_evt_pkg;

  typedef enum logic [1:0] {
    EVT_IDLE     = 2'd0,
    EVT_DEBOUNCE = 2'd1,
    EVT_REQ      = 2'd2,
    EVT_WAIT_REL = 2'd3
  } evt_state_e;

  localparam int unsigned EVT_SYNC_STAGES_DEF = 2;
  localparam int unsigned EVT_DEB_W_DEF       = 4;
  localparam int unsigned EVT_DEB_CNT_DEF     = 8;

  // True when the parameter set is legal: at least two synchroniser flops and
  // a debounce target that fits the counter without wrapping.
  function automatic bit evt_cfg_ok(int unsigned sync_stages,
                                    int unsigned deb_w,
                                    int unsigned deb_cnt);
    bit ok;
    ok = (sync_stages >= 2) && (deb_w >= 1) && (deb_w <= 31) && (deb_cnt >= 1);
    if (ok) ok = (deb_cnt <= ((32'd1 << deb_w) - 32'd1));
    return ok;
  endfunction

endpackage

// File: rtl/scs8hd_evt_sync_cell.sv
// One-bit synchroniser, SYNC_STAGES flops deep, cleared asynchronously by RESETB.
module scs8hd_evt_sync_cell
  import scs8hd_evt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = EVT_SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/scs8hd_evt_sync3.sv
// Event consumer for a 3-input OR: synchronises A/B/C into CLK, debounces the
// ORed level and issues one REQ/ACK handshake per qualified assertion.
// Optional feature macro: SCS8HD_EVT_CAUSE_EN adds the CAUSE snapshot port.
module scs8hd_evt_sync3
  import scs8hd_evt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = EVT_SYNC_STAGES_DEF,
  parameter int unsigned DEB_W       = EVT_DEB_W_DEF,
  parameter int unsigned DEB_CNT     = EVT_DEB_CNT_DEF
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       ACK,
  output logic       REQ,
  output logic       BUSY
`ifdef SCS8HD_EVT_CAUSE_EN
  ,
  output logic [2:0] CAUSE
`endif
);

  if (!evt_cfg_ok(SYNC_STAGES, DEB_W, DEB_CNT)) begin : g_cfg_err
    $error("scs8hd_evt_sync3: illegal SYNC_STAGES/DEB_W/DEB_CNT combination");
  end

  localparam logic [DEB_W-1:0] DEB_CNT_V = DEB_W'(DEB_CNT);
  localparam logic [DEB_W-1:0] CNT_ONE   = DEB_W'(1);

  logic [2:0]       sync_s;
  logic             evt_s;
  evt_state_e       state_q;
  logic [DEB_W-1:0] cnt_q;
  logic             req_q;
  logic             busy_q;

  scs8hd_evt_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk_i (CLK),
    .rst_ni(RESETB),
    .d_i   (A),
    .q_o   (sync_s[0])
  );

  scs8hd_evt_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk_i (CLK),
    .rst_ni(RESETB),
    .d_i   (B),
    .q_o   (sync_s[1])
  );

  scs8hd_evt_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c (
    .clk_i (CLK),
    .rst_ni(RESETB),
    .d_i   (C),
    .q_o   (sync_s[2])
  );

  // Sources are ORed after synchronisation, so swaps among A/B/C with the OR
  // held high look like one continuous event.
  assign evt_s = |sync_s;

  // Handshake FSM with debounce counter; REQ and BUSY are registered with the
  // state they belong to.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= EVT_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        EVT_IDLE: begin
          if (evt_s) begin
            state_q <= EVT_DEBOUNCE;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
          end
        end
        EVT_DEBOUNCE: begin
          if (!evt_s) begin
            state_q <= EVT_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == DEB_CNT_V) begin
            // Counter stays parked at the target instead of wrapping.
            state_q <= EVT_REQ;
            req_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        EVT_REQ: begin
          if (ACK) begin
            state_q <= EVT_WAIT_REL;
            req_q   <= 1'b0;
          end
        end
        EVT_WAIT_REL: begin
          if (!ACK && !evt_s) begin
            state_q <= EVT_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= EVT_IDLE;
          cnt_q   <= '0;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign REQ  = req_q;
  assign BUSY = busy_q;

`ifdef SCS8HD_EVT_CAUSE_EN
  logic [2:0] cause_q;

  // Snapshot the synced sources on the edge that raises REQ; clear on return to IDLE.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      cause_q <= '0;
    end else if (state_q == EVT_DEBOUNCE && evt_s && cnt_q == DEB_CNT_V) begin
      cause_q <= sync_s;
    end else if (state_q == EVT_WAIT_REL && !ACK && !evt_s) begin
      cause_q <= '0;
    end
  end

  assign CAUSE = cause_q;
`endif

endmodule

// File: tb/tb_scs8hd_evt_sync3.sv
// Directed bench for scs8hd_evt_sync3 with a queue of expected REQ/BUSY values.
module tb_scs8hd_evt_sync3;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEB_W       = 4;
  localparam int unsigned DEB_CNT     = 8;
  localparam int          LAT         = SYNC_STAGES + 1 + DEB_CNT;

  logic CLK = 1'b0;
  logic RESETB;
  logic A, B, C, ACK;
  logic REQ, BUSY;
`ifdef SCS8HD_EVT_CAUSE_EN
  logic [2:0] CAUSE;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string tag;
    logic  req;
    logic  busy;
  } exp_t;

  exp_t sb_q[$];

  scs8hd_evt_sync3 #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_W      (DEB_W),
    .DEB_CNT    (DEB_CNT)
  ) dut (
    .CLK   (CLK),
    .RESETB(RESETB),
    .A     (A),
    .B     (B),
    .C     (C),
    .ACK   (ACK),
    .REQ   (REQ),
    .BUSY  (BUSY)
`ifdef SCS8HD_EVT_CAUSE_EN
    ,
    .CAUSE (CAUSE)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic req, input logic busy);
    exp_t e;
    e.tag  = tag;
    e.req  = req;
    e.busy = busy;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_empty observed=0 entries expected=1");
    end else begin
      e = sb_q.pop_front();
      chk_bit({e.tag, "_req"}, REQ, e.req);
      chk_bit({e.tag, "_busy"}, BUSY, e.busy);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Counts edges until REQ rises (bounded) and checks the latency.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (REQ !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk_int(tag, n, LAT);
  endtask

  task automatic window(input int n, output logic req_seen, output logic busy_seen);
    req_seen  = 1'b0;
    busy_seen = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      if (REQ === 1'b1)  req_seen  = 1'b1;
      if (BUSY === 1'b1) busy_seen = 1'b1;
    end
  endtask

  logic rs, bs;

  initial begin
    // 1: reset with A high, then exact latency to REQ
    RESETB = 1'b0; A = 1'b1; B = 1'b0; C = 1'b0; ACK = 1'b0;
    #2;
    sb_push("t1_rst_async", 1'b0, 1'b0);
    sb_check();
    sb_push("t1_rst_held", 1'b0, 1'b0);
    tick(3);
    sb_check();
`ifdef SCS8HD_EVT_CAUSE_EN
    chk_bit("t1_cause_rst", (CAUSE === 3'b000), 1'b1);
`endif
    RESETB = 1'b1;
    sb_push("t1_edge2", 1'b0, 1'b0);
    tick(2);
    sb_check();
    sb_push("t1_edge3", 1'b0, 1'b1);
    tick(1);
    sb_check();
    sb_push("t1_edge10", 1'b0, 1'b1);
    tick(7);
    sb_check();
    sb_push("t1_edge11", 1'b1, 1'b1);
    tick(1);
    sb_check();
    ACK = 1'b1;
    sb_push("t1_ack", 1'b0, 1'b1);
    tick(1);
    sb_check();
    ACK = 1'b0;
    sb_push("t1_held", 1'b0, 1'b1);
    tick(6);
    sb_check();
    A = 1'b0;
    sb_push("t1_release", 1'b0, 1'b0);
    tick(4);
    sb_check();

    // 2: short glitch on B never raises REQ
    B = 1'b1;
    tick(5);
    B = 1'b0;
    window(20, rs, bs);
    chk_bit("t2_no_req", rs, 1'b0);
    chk_bit("t2_busy_pulse", bs, 1'b1);
    sb_push("t2_idle", 1'b0, 1'b0);
    sb_check();

    // 3: C held, one ACK, no retrigger until C toggles
    C = 1'b1;
    wait_req("t3_lat1");
    ACK = 1'b1;
    tick(1);
    ACK = 1'b0;
    sb_push("t3_ack", 1'b0, 1'b1);
    sb_check();
    window(25, rs, bs);
    chk_bit("t3_no_retrig", rs, 1'b0);
    C = 1'b0;
    sb_push("t3_release", 1'b0, 1'b0);
    tick(4);
    sb_check();
    C = 1'b1;
    wait_req("t3_lat2");
    ACK = 1'b1;
    tick(1);
    ACK = 1'b0;
    C = 1'b0;
    tick(4);

    // 4: A and C together, cause snapshot
    A = 1'b1; C = 1'b1;
    wait_req("t4_lat");
`ifdef SCS8HD_EVT_CAUSE_EN
    chk_int("t4_cause", int'(CAUSE), 5);
`endif
    ACK = 1'b1;
    tick(1);
    A = 1'b0; C = 1'b0; ACK = 1'b0;
    sb_push("t4_idle", 1'b0, 1'b0);
    tick(4);
    sb_check();
`ifdef SCS8HD_EVT_CAUSE_EN
    chk_int("t4_cause_clr", int'(CAUSE), 0);
`endif

    // 5: reset mid-handshake
    A = 1'b1;
    wait_req("t5_lat");
    #2;
    RESETB = 1'b0;
    #1;
    sb_push("t5_async_drop", 1'b0, 1'b0);
    sb_check();
    A = 1'b0;
    tick(2);
    RESETB = 1'b1;
    window(20, rs, bs);
    chk_bit("t5_no_replay_req", rs, 1'b0);
    chk_bit("t5_no_replay_busy", bs, 1'b0);

    // 6: ACK held through IDLE does not block debounce
    ACK = 1'b1;
    tick(2);
    A = 1'b1;
    sb_push("t6_edge10", 1'b0, 1'b1);
    tick(10);
    sb_check();
    sb_push("t6_edge11", 1'b1, 1'b1);
    tick(1);
    sb_check();
    sb_push("t6_wait_rel", 1'b0, 1'b1);
    tick(1);
    sb_check();
    A = 1'b0; ACK = 1'b0;
    sb_push("t6_idle", 1'b0, 1'b0);
    tick(4);
    sb_check();

    chk_int("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
